// File: rtl/alu_issue_arbiter.sv
// alu_issue_arbiter
// Two-slot round-robin issue arbiter in front of one shared combinational ALU.
// Pipeline: request select -> ISS register (drives the ALU) -> RES register.
// Full valid/ready backpressure from the result side at one op per cycle.
//
// Optional feature macro: ALU_ARB_OPCHECK_EN
//   defined   : op codes 0101-1111 flow through the pipe but the ALU sees 0000,
//               the result is forced to zero and res_err is raised.
//   undefined : op codes pass to the ALU unchanged and res_err is tied low.

module alu_issue_arbiter #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [2*DATA_W-1:0] req_a,
  input  logic [2*DATA_W-1:0] req_b,
  input  logic [7:0]          req_op,
  input  logic [2*TAG_W-1:0]  req_tag,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  output logic [3:0]          alu_control,
  input  logic [DATA_W-1:0]   alu_result,
  input  logic                alu_zero,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [DATA_W-1:0]   res_data,
  output logic                res_zero,
  output logic [TAG_W-1:0]    res_tag,
  output logic                res_src,
  output logic                res_err
);

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_ADD = 4'b0010,
    OP_SUB = 4'b0011,
    OP_XOR = 4'b0100
  } alu_op_e;

  // Round-robin pointer: slot that wins when both request.
  logic              prio;
  logic [1:0]        grant;
  logic              res_free;
  logic              iss_free;
  logic              accept;
  logic              acc_slot;

  // Issue-stage register.
  logic              iss_valid;
  logic [DATA_W-1:0] iss_a;
  logic [DATA_W-1:0] iss_b;
  logic [3:0]        iss_op;
  logic [TAG_W-1:0]  iss_tag;
  logic              iss_src;

  // Values captured into RES when the issue stage advances.
  logic [DATA_W-1:0] cap_data;
  logic              cap_zero;
  logic              cap_err;

  assign res_free = !res_valid || res_ready;
  assign iss_free = !iss_valid || res_free;

  // Grant selection: a lone requester wins, a tie goes to the priority slot.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; a missing default infers a latch.
    grant = 2'b00;
    case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = prio ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  // Ready is held low throughout reset so nothing is taken while the pipe clears.
  assign req_ready = rst_n ? (grant & {2{iss_free}}) : 2'b00;
  assign accept    = |req_ready;
  assign acc_slot  = req_ready[1];

  // Round-robin pointer moves to the other slot after every accept.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values regardless of statement order.
    if (!rst_n) begin
      prio <= 1'b0;
    end else if (accept) begin
      prio <= ~acc_slot;
    end
  end

  // Issue stage: load the granted request, hold operands when empty.
  always_ff @(posedge clk) begin
    // NOTE: the datapath fields are reset too because they drive the ALU
    // outputs, which must read zero out of reset.
    if (!rst_n) begin
      iss_valid <= 1'b0;
      iss_a     <= '0;
      iss_b     <= '0;
      iss_op    <= 4'b0000;
      iss_tag   <= '0;
      iss_src   <= 1'b0;
    end else if (iss_free) begin
      iss_valid <= accept;
      if (accept) begin
        iss_a   <= acc_slot ? req_a[2*DATA_W-1:DATA_W] : req_a[DATA_W-1:0];
        iss_b   <= acc_slot ? req_b[2*DATA_W-1:DATA_W] : req_b[DATA_W-1:0];
        iss_op  <= acc_slot ? req_op[7:4] : req_op[3:0];
        iss_tag <= acc_slot ? req_tag[2*TAG_W-1:TAG_W] : req_tag[TAG_W-1:0];
        iss_src <= acc_slot;
      end
    end
  end

  assign alu_a = iss_a;
  assign alu_b = iss_b;

`ifdef ALU_ARB_OPCHECK_EN
  logic iss_illegal;

  assign iss_illegal = (iss_op > OP_XOR);
  // Illegal codes are replaced by AND at the ALU and yield a flagged zero result.
  assign alu_control = iss_illegal ? OP_AND : iss_op;
  assign cap_data    = iss_illegal ? '0 : alu_result;
  assign cap_zero    = iss_illegal ? 1'b0 : alu_zero;
  assign cap_err     = iss_illegal;
`else
  assign alu_control = iss_op;
  assign cap_data    = alu_result;
  assign cap_zero    = alu_zero;
  assign cap_err     = 1'b0;
`endif

  // Result stage: capture the ALU output when issue advances, clear on drain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_zero  <= 1'b0;
      res_tag   <= '0;
      res_src   <= 1'b0;
      res_err   <= 1'b0;
    end else if (res_free) begin
      res_valid <= iss_valid;
      if (iss_valid) begin
        res_data <= cap_data;
        res_zero <= cap_zero;
        res_tag  <= iss_tag;
        res_src  <= iss_src;
        res_err  <= cap_err;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Scoreboard bench for alu_issue_arbiter: directed requests push hand-computed
// results at acceptance, a negedge monitor pops and compares each result.
module tb_alu_issue_arbiter;

  localparam int DW = 32;
  localparam int TW = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [2*DW-1:0] req_a;
  logic [2*DW-1:0] req_b;
  logic [7:0]      req_op;
  logic [2*TW-1:0] req_tag;
  logic [DW-1:0]   alu_a;
  logic [DW-1:0]   alu_b;
  logic [3:0]      alu_control;
  logic [DW-1:0]   alu_result;
  logic            alu_zero;
  logic            res_valid;
  logic            res_ready;
  logic [DW-1:0]   res_data;
  logic            res_zero;
  logic [TW-1:0]   res_tag;
  logic            res_src;
  logic            res_err;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          zero;
    logic [TW-1:0] tag;
    logic          src;
    logic          err;
  } exp_t;

  exp_t pend [2];
  exp_t sb[$];
  exp_t mon_e;
  logic acc_src[$];
  int   acc_cyc[$];
  int   res_cyc[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic [DW+TW+1:0] held;

`ifdef ALU_ARB_OPCHECK_EN
  localparam logic [DW-1:0] ILL_DATA = 32'h0;
  localparam logic          ILL_ERR  = 1'b1;
  localparam logic [3:0]    ILL_CTRL = 4'h0;
`else
  localparam logic [DW-1:0] ILL_DATA = 32'hA5A5_A5A5;
  localparam logic          ILL_ERR  = 1'b0;
  localparam logic [3:0]    ILL_CTRL = 4'hF;
`endif

  alu_issue_arbiter #(.DATA_W(DW), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_tag(req_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_zero(res_zero), .res_tag(res_tag),
    .res_src(res_src), .res_err(res_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference ALU; illegal codes return a recognisable pattern.
  always_comb begin
    alu_result = 32'hA5A5_A5A5;
    case (alu_control)
      4'h0:    alu_result = alu_a & alu_b;
      4'h1:    alu_result = alu_a | alu_b;
      4'h2:    alu_result = alu_a + alu_b;
      4'h3:    alu_result = alu_a - alu_b;
      4'h4:    alu_result = alu_a ^ alu_b;
      default: alu_result = 32'hA5A5_A5A5;
    endcase
    alu_zero = (alu_control <= 4'h4) && (alu_result == '0);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare each delivered result, record each accept.
  always @(negedge clk) begin
    if (rst_n) begin
      if (res_valid && res_ready) begin
        if (sb.size() == 0) begin
          check("res_unexpected_sb_size", 64'(sb.size()), 1);
        end else begin
          mon_e = sb.pop_front();
          check("res_data", res_data, mon_e.data);
          check("res_zero", res_zero, mon_e.zero);
          check("res_tag",  res_tag,  mon_e.tag);
          check("res_src",  res_src,  mon_e.src);
          check("res_err",  res_err,  mon_e.err);
          res_cyc.push_back(cyc);
        end
      end
      for (int i = 0; i < 2; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          sb.push_back(pend[i]);
          acc_src.push_back(i[0]);
          acc_cyc.push_back(cyc);
        end
      end
    end
  end

  // Present one request on slot s and hold it until accepted (bounded).
  task automatic send(input int s, input logic [3:0] op, input logic [DW-1:0] a,
                      input logic [DW-1:0] b, input logic [TW-1:0] tag,
                      input logic [DW-1:0] d, input logic z, input logic err);
    bit ok = 0;
    pend[s] = '{data: d, zero: z, tag: tag, src: s[0], err: err};
    if (s == 0) begin
      req_a[DW-1:0] = a; req_b[DW-1:0] = b; req_op[3:0] = op; req_tag[TW-1:0] = tag;
    end else begin
      req_a[2*DW-1:DW] = a; req_b[2*DW-1:DW] = b; req_op[7:4] = op; req_tag[2*TW-1:TW] = tag;
    end
    req_valid[s] = 1'b1;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      if (req_ready[s]) ok = 1;
    end
    if (!ok) check($sformatf("accept_timeout_slot%0d", s), req_ready[s], 1);
    @(posedge clk); #1;
    req_valid[s] = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; res_ready = 1'b1; req_valid = 2'b11;
    req_a = '0; req_b = '0; req_op = '0; req_tag = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", req_ready, 2'b00);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alu_control", alu_control, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_zero", res_zero, 0);
    check("rst_res_tag", res_tag, 0);
    check("rst_res_src", res_src, 0);
    check("rst_res_err", res_err, 0);
    @(posedge clk); #1;
    req_valid = 2'b00; rst_n = 1'b1;

    // Single ADD on slot 0: ALU driven the cycle after accept, result one later.
    @(posedge clk); #1;
    send(0, 4'h2, 10, 20, 3, 30, 1'b0, 1'b0);
    @(negedge clk);
    check("lat_res_valid_early", res_valid, 0);
    check("lat_alu_a", alu_a, 10);
    check("lat_alu_b", alu_b, 20);
    check("lat_alu_control", alu_control, 4'h2);
    @(negedge clk);
    check("lat_res_valid", res_valid, 1);

    // SUB giving zero on slot 1.
    send(1, 4'h3, 5, 5, 5, 0, 1'b1, 1'b0);
    repeat (3) @(negedge clk);

    // Both slots streaming: alternate grants, one result per cycle.
    @(posedge clk); #1;
    acc_src.delete(); acc_cyc.delete(); res_cyc.delete();
    fork
      begin
        send(0, 4'h0, 32'hFFFF_0000, 32'h0F0F_0F0F, 1, 32'h0F0F_0000, 1'b0, 1'b0);
        send(0, 4'h1, 32'h0000_00F0, 32'h0000_0F00, 2, 32'h0000_0FF0, 1'b0, 1'b0);
        send(0, 4'h4, 32'hAAAA_5555, 32'hAAAA_5555, 4, 32'h0, 1'b1, 1'b0);
        send(0, 4'h2, 32'hFFFF_FFFF, 32'h1, 6, 32'h0, 1'b1, 1'b0);
      end
      begin
        send(1, 4'h3, 3, 5, 7, 32'hFFFF_FFFE, 1'b0, 1'b0);
        send(1, 4'h2, 100, 200, 8, 300, 1'b0, 1'b0);
        send(1, 4'h0, 32'h0, 32'hFFFF, 9, 32'h0, 1'b1, 1'b0);
        send(1, 4'h1, 32'h0, 32'h8000_0000, 10, 32'h8000_0000, 1'b0, 1'b0);
      end
    join
    repeat (4) @(negedge clk);
    check("stream_accepts", 64'(acc_src.size()), 8);
    for (int i = 0; i < acc_src.size(); i++)
      check($sformatf("stream_src%0d", i), acc_src[i], 64'(i % 2));
    if (acc_cyc.size() == 8) check("stream_accept_span", 64'(acc_cyc[7] - acc_cyc[0]), 7);
    check("stream_results", 64'(res_cyc.size()), 8);
    if (res_cyc.size() == 8) check("stream_result_span", 64'(res_cyc[7] - res_cyc[0]), 7);

    // Backpressure: two accepted, third blocked, RES held stable.
    @(posedge clk); #1;
    res_ready = 1'b0;
    fork
      begin
        send(0, 4'h2, 1, 2, 11, 3, 1'b0, 1'b0);
        send(0, 4'h4, 32'hF, 32'h3, 13, 32'hC, 1'b0, 1'b0);
      end
      send(1, 4'h3, 9, 4, 12, 5, 1'b0, 1'b0);
    join_none
    repeat (5) @(negedge clk);
    check("stall_req_ready", req_ready, 2'b00);
    check("stall_res_valid", res_valid, 1);
    check("stall_res_data", res_data, 3);
    check("stall_sb_size", 64'(sb.size()), 2);
    held = {res_data, res_zero, res_tag, res_src};
    repeat (3) @(negedge clk);
    check("stall_res_stable", {res_data, res_zero, res_tag, res_src}, held);
    @(posedge clk); #1;
    res_ready = 1'b1;
    @(negedge clk);
    check("unstall_same_cycle_accept", req_ready, 2'b01);
    wait fork;
    repeat (4) @(negedge clk);

    // Reset with both stages full.
    @(posedge clk); #1;
    res_ready = 1'b0;
    fork
      send(0, 4'h0, 3, 1, 1, 1, 1'b0, 1'b0);
      send(1, 4'h1, 4, 0, 2, 4, 1'b0, 1'b0);
    join
    @(negedge clk);
    check("full_req_ready", req_ready, 2'b00);
    check("full_res_valid", res_valid, 1);
    @(posedge clk); #1;
    rst_n = 1'b0; sb.delete(); req_valid = 2'b11;
    @(negedge clk);
    check("in_rst_req_ready", req_ready, 2'b00);
    @(posedge clk); #1;
    rst_n = 1'b1; req_valid = 2'b00;
    @(negedge clk);
    check("post_rst_res_valid", res_valid, 0);
    check("post_rst_req_ready", req_ready, 2'b00);
    @(posedge clk); #1;
    res_ready = 1'b1;
    acc_src.delete();
    fork
      send(0, 4'h2, 7, 8, 1, 15, 1'b0, 1'b0);
      send(1, 4'h1, 1, 2, 2, 3, 1'b0, 1'b0);
    join
    check("post_rst_accepts", 64'(acc_src.size()), 2);
    if (acc_src.size() > 0) check("post_rst_first_grant", acc_src[0], 0);
    repeat (3) @(negedge clk);

    // Illegal op code 1111.
    send(1, 4'hF, 7, 9, 14, ILL_DATA, 1'b0, ILL_ERR);
    @(negedge clk);
    check("illegal_alu_control", alu_control, ILL_CTRL);

    for (int k = 0; k < 50 && sb.size() != 0; k++) @(negedge clk);
    check("drain_sb_empty", 64'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
